// File: rtl/add_share_arb.sv
// Round-robin arbiter that time-shares one WIDTH-bit adder among N_REQ requesters.
// One operation in flight: grant and latch operands, add, then hold the tagged result until taken.
//
// state | meaning
// IDLE  | search for a winner from last_grant+1, accept its operands on handshake
// EXEC  | operand registers drive the adder, result registered at the edge
// RESP  | result held on resp_* until resp_ready
module add_share_arb #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [WIDTH-1:0]       resp_sum,
  output logic                   resp_carry
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   cur_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [WIDTH:0]   add_res;

  // Rotating priority: the requester right after the last grant is searched first.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!grant_found && req_valid[(int'(last_grant) + k) % N_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'((int'(last_grant) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    win_a = req_a[int'(grant_idx)*WIDTH +: WIDTH];
    win_b = req_b[int'(grant_idx)*WIDTH +: WIDTH];
  end

  // Grant depends only on state, rst, req_valid and last_grant; never on resp_ready.
  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign add_res = {1'b0, op_a} + {1'b0, op_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDW'(N_REQ - 1);
      cur_id     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
      resp_carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a       <= win_a;
            op_b       <= win_b;
            cur_id     <= grant_idx;
            last_grant <= grant_idx;
            state      <= EXEC;
          end
        end
        EXEC: begin
          resp_sum   <= add_res[WIDTH-1:0];
          resp_carry <= add_res[WIDTH];
          resp_id    <= cur_id;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_share_arb.sv
// Directed self-checking bench for add_share_arb (N_REQ=4, WIDTH=32).
// Inputs change on the falling edge; outputs are sampled there or 1 time unit later.
module tb_add_share_arb;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [1:0]   resp_id;
  logic [31:0]  resp_sum;
  logic         resp_carry;

  int vectors = 0;
  int miscompares = 0;

  add_share_arb #(.N_REQ(4), .WIDTH(32), .IDW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_carry (resp_carry)
  );

  always #5 clk = ~clk;

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'hF;
    resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_forces_ready: got %b want 0000", req_ready);
    end
    req_valid = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0 || resp_sum !== 32'h0 || resp_carry !== 1'b0 || resp_id !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b sum=%h c=%b id=%0d want 0 0 0 0",
               resp_valid, resp_sum, resp_carry, resp_id);
    end
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL idle_no_req: got %b want 0000", req_ready);
    end
  endtask

  task automatic test_single();
    set_op(1, 32'h0000_0005, 32'h0000_0007);
    req_valid = 4'b0010;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL single_grant: got %b want 0010", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    vectors++;
    if (resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_exec_valid: got %b want 0", resp_valid);
    end
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_sum !== 32'h0000_000C || resp_carry !== 1'b0) begin
      miscompares++;
      $display("FAIL single_resp: got v=%b id=%0d sum=%h c=%b want 1 1 0000000c 0",
               resp_valid, resp_id, resp_sum, resp_carry);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    vectors++;
    if (resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_resp_drop: got %b want 0", resp_valid);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ta [2];
    logic [31:0] tb [2];
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'h0000_0001;
    ta[1] = 32'h8000_0000; tb[1] = 32'h8000_0000;
    for (int v = 0; v < 2; v++) begin
      set_op(0, ta[v], tb[v]);
      req_valid = 4'b0001;
      #1;
      vectors++;
      if (req_ready !== 4'b0001) begin
        miscompares++;
        $display("FAIL wrap_grant[%0d]: got %b want 0001", v, req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0000;
      for (int i = 0; i < 8 && resp_valid !== 1'b1; i++) @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_sum !== 32'h0 || resp_carry !== 1'b1) begin
        miscompares++;
        $display("FAIL wrap_resp[%0d]: got v=%b id=%0d sum=%h c=%b want 1 0 00000000 1",
                 v, resp_valid, resp_id, resp_sum, resp_carry);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_fairness();
    logic [3:0]  gr_onehot [8];
    int          gr_cyc [8];
    logic [1:0]  rid [8];
    logic [31:0] rsum [8];
    int ngr = 0;
    int nresp = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 32'(i), 32'h10);
    req_valid = 4'hF;
    resp_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && nresp < 6; cyc++) begin
      #1;
      if (req_ready !== 4'b0000) begin
        if (ngr < 8) begin
          gr_onehot[ngr] = req_ready;
          gr_cyc[ngr] = cyc;
        end
        ngr++;
      end
      if (resp_valid === 1'b1 && nresp < 8) begin
        rid[nresp] = resp_id;
        rsum[nresp] = resp_sum;
        nresp++;
      end
      @(negedge clk);
    end
    req_valid = 4'h0;
    vectors++;
    if (nresp != 6 || ngr < 6) begin
      miscompares++;
      $display("FAIL fair_count: got resp=%0d grants=%0d want 6 6", nresp, ngr);
    end else begin
      for (int k = 0; k < 6; k++) begin
        vectors++;
        if (gr_onehot[k] !== 4'(1 << (k % 4))) begin
          miscompares++;
          $display("FAIL fair_grant[%0d]: got %b want %b", k, gr_onehot[k], 4'(1 << (k % 4)));
        end
        vectors++;
        if (rid[k] !== 2'(k % 4) || rsum[k] !== 32'h10 + 32'(k % 4)) begin
          miscompares++;
          $display("FAIL fair_resp[%0d]: got id=%0d sum=%h want %0d %h",
                   k, rid[k], rsum[k], k % 4, 32'h10 + 32'(k % 4));
        end
        if (k < 5) begin
          vectors++;
          if (gr_cyc[k+1] - gr_cyc[k] != 3) begin
            miscompares++;
            $display("FAIL fair_interval[%0d]: got %0d want 3", k, gr_cyc[k+1] - gr_cyc[k]);
          end
        end
      end
    end
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    set_op(0, 32'h1234_5678, 32'h0FED_CBA9);
    set_op(2, 32'h0000_0003, 32'h0000_0004);
    req_valid = 4'b0001;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL bp_grant0: got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    vectors++;
    if (req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL bp_exec_ready: got %b want 0000", req_ready);
    end
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_sum !== 32'h2222_2221 ||
          resp_carry !== 1'b0 || req_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%0d sum=%h c=%b rdy=%b want 1 0 22222221 0 0000",
                 c, resp_valid, resp_id, resp_sum, resp_carry, req_ready);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 4'b0100 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_next_grant: got rdy=%b v=%b want 0100 0", req_ready, resp_valid);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    for (int i = 0; i < 8 && resp_valid !== 1'b1; i++) @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_sum !== 32'h7 || resp_carry !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_resp2: got v=%b id=%0d sum=%h c=%b want 1 2 00000007 0",
               resp_valid, resp_id, resp_sum, resp_carry);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    set_op(3, 32'hDEAD_BEEF, 32'h0000_0001);
    req_valid = 4'b1000;
    #1;
    vectors++;
    if (req_ready !== 4'b1000) begin
      miscompares++;
      $display("FAIL rmid_grant3: got %b want 1000", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (resp_valid !== 1'b0 || resp_sum !== 32'h0 || resp_carry !== 1'b0 || resp_id !== 2'd0) begin
      miscompares++;
      $display("FAIL rmid_outputs: got v=%b sum=%h c=%b id=%0d want 0 0 0 0",
               resp_valid, resp_sum, resp_carry, resp_id);
    end
    for (int i = 0; i < 4; i++) begin
      if (resp_valid === 1'b1) seen++;
      @(negedge clk);
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL rmid_no_resp: got %0d response cycles want 0", seen);
    end
    set_op(0, 32'h0000_0100, 32'h0000_0200);
    req_valid = 4'b1001;
    #1;
    vectors++;
    if (req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL rmid_prio0: got %b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    for (int i = 0; i < 8 && resp_valid !== 1'b1; i++) @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_sum !== 32'h300) begin
      miscompares++;
      $display("FAIL rmid_resp0: got v=%b id=%0d sum=%h want 1 0 00000300", resp_valid, resp_id, resp_sum);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_withdrawn();
    int bad = 0;
    set_op(0, 32'h0000_0020, 32'h0000_0002);
    set_op(1, 32'h0000_0009, 32'h0000_0001);
    set_op(2, 32'h0000_0055, 32'h0000_0055);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    for (int i = 0; i < 8 && resp_valid !== 1'b1; i++) @(negedge clk);
    req_valid = 4'b0100;
    #1;
    vectors++;
    if (resp_valid !== 1'b1 || resp_sum !== 32'h22 || req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL wd_resp_phase: got v=%b sum=%h rdy=%b want 1 00000022 0000", resp_valid, resp_sum, req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    vectors++;
    if (req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL wd_grant1: got %b want 0010", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    for (int i = 0; i < 8 && resp_valid !== 1'b1; i++) @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_sum !== 32'h0A) begin
      miscompares++;
      $display("FAIL wd_resp1: got v=%b id=%0d sum=%h want 1 1 0000000a", resp_valid, resp_id, resp_sum);
    end
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) bad++;
    end
    resp_ready = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL wd_no_resp2: got %0d extra response cycles want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_withdrawn();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/add_share_arb.md
# add_share_arb

Round-robin arbiter and sequencer that shares one 32-bit adder datapath among `N_REQ` requesters. Each requester issues an operand pair over a valid/ready handshake. The block grants one requester at a time, registers the operands, drives the shared adder, and returns the registered sum and carry tagged with the requester index over a response handshake. It sits between the issuing units and the ALU's `Add` instance.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 32: operand and sum width; must match the shared adder.
- `IDW`, 2: requester-id width, equal to clog2(`N_REQ`).

Ports:
- `clk`  in  1: the single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  `N_REQ`: per-requester operand-valid.
- `req_ready`  out  `N_REQ`: per-requester accept, one-hot or zero.
- `req_a`  in  `N_REQ*WIDTH`: packed operand A; requester i uses bits [i*WIDTH +: WIDTH].
- `req_b`  in  `N_REQ*WIDTH`: packed operand B, packed the same way.
- `resp_valid`  out  1: result available.
- `resp_ready`  in  1: consumer accepts the result.
- `resp_id`  out  `IDW`: index of the requester that owns the result.
- `resp_sum`  out  `WIDTH`: (a + b) mod 2^WIDTH.
- `resp_carry`  out  1: carry out of bit `WIDTH`-1.

## Operation
- FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Winner = first i with `req_valid[i]`=1, searching from `last_grant`+1 upward modulo `N_REQ`.
  - `req_ready[winner]`=1 combinationally in the same cycle; all other `req_ready` bits are 0.
  - Handshake (valid and ready both high): latch the winner's `req_a` / `req_b` into operand registers, latch winner into `cur_id`, set `last_grant` := winner, go to EXEC.
  - No valid request: stay in IDLE; all `req_ready`=0.
- EXEC:
  - Operand registers drive the shared adder (combinational, `WIDTH`+1-bit result).
  - At the clock edge, register the sum into `resp_sum` and the carry into `resp_carry`; set `resp_id` := `cur_id`, `resp_valid` := 1; go to RESP.
- RESP:
  - Hold `resp_valid`, `resp_id`, `resp_sum` and `resp_carry` stable until `resp_ready`=1.
  - On the handshake edge: `resp_valid` := 0, go to IDLE.
- `req_ready` is 0 in EXEC and RESP. Only one operation is in flight at a time.
- A requester may drop `req_valid` before it is granted; no state is retained for it.
- Arithmetic is unsigned, modulo 2^`WIDTH`. Signed interpretation is left to the consumer.

## Timing
- Reset values:
  - `req_ready` = 0 (`rst` forces it low combinationally).
  - `resp_valid` = 0, `resp_sum` = 0, `resp_carry` = 0, `resp_id` = 0.
  - Operand registers = 0, `cur_id` = 0.
  - `last_grant` = `N_REQ`-1, so requester 0 has first priority.
- Latency: request accepted on edge T gives `resp_valid`=1 from edge T+1, visible in cycle T+1 to T+2.
- Accept-to-response latency is 2 cycles. Minimum issue interval is 3 cycles when `resp_ready` is held high.
- The grant decision uses the current-cycle `req_valid` and the registered `last_grant`. There is no combinational path from `resp_ready` to `req_ready`.
- `rst` in any state (including EXEC and RESP with a held result):
  - Next state is IDLE, `resp_valid`=0, and the in-flight result is discarded.
  - `last_grant` returns to `N_REQ`-1.
  - No grant is issued in the `rst` cycle.
- All valid simultaneously: grant order rotates strictly, so every requester is served within `N_REQ` grants.
- `resp_ready` held high while `resp_valid`=0 has no effect.

## Test plan
- Single request, sum with carry:
  - Stimulus: after reset, req 1 valid with a=0x0000_0005, b=0x0000_0007.
  - Response: `req_ready`=0b0010 in the same cycle; two cycles later `resp_valid`=1, `resp_id`=1, `resp_sum`=0x0000_000C, `resp_carry`=0.
- Wrap-around:
  - Stimulus: req 0 with a=0xFFFF_FFFF, b=0x0000_0001.
  - Response: `resp_sum`=0x0000_0000, `resp_carry`=1.
  - Stimulus: a=0x8000_0000, b=0x8000_0000.
  - Response: `resp_sum`=0, `resp_carry`=1.
- Fairness:
  - Stimulus: all four valid continuously, operands a=i, b=0x10; `resp_ready`=1.
  - Response: `resp_id` sequence 0,1,2,3,0,1; sums 0x10,0x11,0x12,0x13; issue interval exactly 3 cycles.
- Backpressure:
  - Stimulus: hold `resp_ready`=0 for 5 cycles while in RESP with req 2 pending.
  - Response: `resp_valid`, `resp_id`, `resp_sum` and `resp_carry` stay stable and `req_ready`=0 throughout; req 2 is granted in the first IDLE cycle after the handshake.
- Reset mid-operation:
  - Stimulus: assert `rst` for one cycle while in EXEC with req 3's operands latched.
  - Response: no response appears; all outputs return to reset values; the next simultaneous req 0 and req 3 grants req 0.
- Withdrawn request:
  - Stimulus: req 2 valid for one cycle while in RESP, then deasserted; next, req 1 valid.
  - Response: only req 1 is granted; no response carries `resp_id`=2.
